// File: rtl/switch_io_pkg.sv
// ---------------------------------------------------------------------------
// switch_io_pkg
// Shared constants and types for the slide-switch input path.
//   SW_WIDTH            number of board slide switches
//   SW_DEBOUNCE_DEFAULT debounce window in clocks (20 ms at 100 MHz)
//   SW_DEBOUNCE_SIM     short debounce window for simulation
//   SW_IO_ADDR          address the CPU IO decode maps the switch word to
//   db_state_e          per-bit debounce state
// ---------------------------------------------------------------------------
package switch_io_pkg;

    localparam int SW_WIDTH            = 16;
    localparam int SW_DEBOUNCE_DEFAULT = 2000000;
    localparam int SW_DEBOUNCE_SIM     = 4;

    // Word address of the switch register in the CPU's IO space.
    localparam logic [31:0] SW_IO_ADDR = 32'hFFFF_FC70;

    // IDLE: synchronised input agrees with the stable value, counter is 0.
    // COUNT: synchronised input disagrees, counter runs toward acceptance.
    typedef enum logic [0:0] {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// One switch bit: two-flop synchroniser followed by a debounce counter.
// A change on the synchronised input is accepted only after it has been
// held for DEBOUNCE_CYCLES consecutive clocks; shorter pulses are dropped.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   sw_raw       asynchronous switch level
//   stable       debounced level (registered)
//   rise_strobe  high in the cycle whose closing edge accepts a 0->1 change
//   fall_strobe  high in the cycle whose closing edge accepts a 1->0 change
//
// The strobes are decoded from registered state only, so the parent can
// register them on the same edge that updates 'stable'.
// DEBOUNCE_CYCLES must be at least 2.
// ---------------------------------------------------------------------------
module debounce_bit
    import switch_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic stable,
    output logic rise_strobe,
    output logic fall_strobe
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             s1_reg;
    logic             s2_reg;
    db_state_e        state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             stable_reg, stable_next;

    // Synchroniser: only s2_reg is used past this point.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= sw_raw;
            s2_reg <= s1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= DB_IDLE;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        rise_strobe = 1'b0;
        fall_strobe = 1'b0;

        unique case (state_reg)
            DB_IDLE: begin
                // First disagreeing edge counts as cycle 1 of the window.
                if (s2_reg != stable_reg) begin
                    state_next = DB_COUNT;
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            DB_COUNT: begin
                if (s2_reg == stable_reg) begin
                    // Input went back before the window closed: a glitch.
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_TERM) begin
                    // Held for the full window; accept. Clearing here is what
                    // keeps the counter from ever wrapping.
                    state_next  = DB_IDLE;
                    cnt_next    = '0;
                    stable_next = s2_reg;
                    rise_strobe = s2_reg;
                    fall_strobe = ~s2_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign stable = stable_reg;

endmodule

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// Conditions the board slide switches for the CPU's switch read path.
// Each bit is synchronised and debounced by a debounce_bit instance; the top
// optionally keeps sticky rise/fall masks that a CPU read clears.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   sw_raw      asynchronous switch levels
//   rd_ack      one-cycle pulse when the CPU reads the switch address
//   sw_stable   debounced switch word (registered)
//   sw_rise     sticky mask of accepted 0->1 changes since last rd_ack
//   sw_fall     sticky mask of accepted 1->0 changes since last rd_ack
//   sw_changed  registered OR of sw_rise | sw_fall
//
// Build option
//   SWITCH_EDGE_CAPTURE_EN  when defined, the event masks and sw_changed are
//                           built. Otherwise they are tied to 0 and rd_ack
//                           is ignored; sw_stable behaves the same either way.
// ---------------------------------------------------------------------------
module switch_debounce
    import switch_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] rise_strobe;
    logic [WIDTH-1:0] fall_strobe;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce_bit (
                .clk         (clk),
                .rst         (rst),
                .sw_raw      (sw_raw[gi]),
                .stable      (sw_stable[gi]),
                .rise_strobe (rise_strobe[gi]),
                .fall_strobe (fall_strobe[gi])
            );
        end
    endgenerate

`ifdef SWITCH_EDGE_CAPTURE_EN

    logic [WIDTH-1:0] rise_reg, rise_next;
    logic [WIDTH-1:0] fall_reg, fall_next;
    logic             changed_reg, changed_next;

    // A strobe arriving on the same edge as rd_ack wins, so the CPU never
    // loses an event that lands exactly on its read.
    always_comb begin
        rise_next    = (rise_reg & ~{WIDTH{rd_ack}}) | rise_strobe;
        fall_next    = (fall_reg & ~{WIDTH{rd_ack}}) | fall_strobe;
        // Derived from the next-state masks so it moves with them.
        changed_next = |(rise_next | fall_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_reg    <= '0;
            fall_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            rise_reg    <= rise_next;
            fall_reg    <= fall_next;
            changed_reg <= changed_next;
        end
    end

    assign sw_rise    = rise_reg;
    assign sw_fall    = fall_reg;
    assign sw_changed = changed_reg;

`else

    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign sw_changed = 1'b0;

    // Event capture is not built; these inputs are intentionally dropped.
    logic unused_event_in;
    assign unused_event_in = &{1'b0, rd_ack, rise_strobe, fall_strobe};

`endif

endmodule

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce
// Directed bench for switch_debounce with a 4-cycle debounce window.
// Expected event masks follow the SWITCH_EDGE_CAPTURE_EN setting of the
// build: with the feature off they must stay 0.
// ---------------------------------------------------------------------------
module tb_switch_debounce;
    import switch_io_pkg::*;

    localparam int W = SW_WIDTH;

`ifdef SWITCH_EDGE_CAPTURE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic         rd_ack;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int pass_cnt  = 0;
    int total_cnt = 0;

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (SW_DEBOUNCE_SIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .rd_ack     (rd_ack),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Event-side expectation: the value when capture is built, else 0.
    function automatic logic [W-1:0] ev(input logic [W-1:0] v);
        return EDGE_EN ? v : '0;
    endfunction

    task automatic check_all(input string tag, input logic [W-1:0] e_stable,
                             input logic [W-1:0] e_rise,
                             input logic [W-1:0] e_fall, input logic e_chg);
        check({tag, ".stable"},  sw_stable, e_stable);
        check({tag, ".rise"},    sw_rise,   ev(e_rise));
        check({tag, ".fall"},    sw_fall,   ev(e_fall));
        check({tag, ".changed"}, {{(W-1){1'b0}}, sw_changed},
              ev({{(W-1){1'b0}}, e_chg}));
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        rd_ack = 1'b0;
        sw_raw = 16'hFFFF;

        // 1: reset with all switches up
        tick();
        check_all("rst_cyc1", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        check_all("rst_cyc2", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        tick(5);
        check_all("rst_up_e5", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        check_all("rst_up_e6", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
        $display("txn reset_up: stable=%h rise=%h chg=%b", sw_stable, sw_rise, sw_changed);

        // Bring everything down, then clear the events.
        ack();
        check_all("ack1", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        sw_raw = 16'h0000;
        tick(6);
        check_all("all_down", 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        ack();
        check_all("ack2", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        $display("txn all_down: stable=%h fall cleared", sw_stable);

        // 2: clean change on bit 0
        sw_raw = 16'h0001;
        tick(5);
        check_all("clean_e4", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        check_all("clean_e5", 16'h0001, 16'h0001, 16'h0000, 1'b1);
        $display("txn clean_bit0: stable=%h rise=%h", sw_stable, sw_rise);

        // 4a: ack clears flags
        ack();
        check_all("ack3", 16'h0001, 16'h0000, 16'h0000, 1'b0);
        $display("txn ack: rise=%h chg=%b", sw_rise, sw_changed);

        // 3: 3-cycle glitch on bit 3 must be rejected
        sw_raw = 16'h0009;
        tick(3);
        sw_raw = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("glitch", 16'h0001, 16'h0000, 16'h0000, 1'b0);
        end
        $display("txn glitch_bit3: stable=%h rise=%h", sw_stable, sw_rise);

        // 4b: bit 5 acceptance on the same edge as rd_ack
        sw_raw = 16'h0021;
        tick(5);
        check_all("race_pre", 16'h0001, 16'h0000, 16'h0000, 1'b0);
        ack();
        check_all("race", 16'h0021, 16'h0020, 16'h0000, 1'b1);
        $display("txn ack_race_bit5: rise=%h chg=%b", sw_rise, sw_changed);

        // 5: reset while bit 7 is mid-count (counter at 2)
        ack();
        sw_raw = 16'h00A1;
        tick(4);
        rst = 1'b1;
        tick();
        check_all("midrst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        tick(5);
        check_all("midrst_e5", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        check_all("midrst_e6", 16'h00A1, 16'h00A1, 16'h0000, 1'b1);
        $display("txn reset_midcount: stable=%h rise=%h", sw_stable, sw_rise);

        // Toggle down and up again without an ack: both masks stick.
        sw_raw = 16'h0000;
        tick(6);
        check_all("fall_sticky", 16'h0000, 16'h00A1, 16'h00A1, 1'b1);
        sw_raw = 16'h0080;
        tick(6);
        check_all("rise_again", 16'h0080, 16'h00A1, 16'h00A1, 1'b1);
        ack();
        check_all("ack_final", 16'h0080, 16'h0000, 16'h0000, 1'b0);
        $display("txn double_toggle: stable=%h", sw_stable);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
